// File: rtl/dmux_pkg.sv
// Shared constants and types for the four-way stream demultiplexer.
// Optional per-channel delivery counters are enabled by DMUX_COUNT_EN.
package dmux_pkg;

  localparam int NUM_CH    = 4;
  localparam int DEF_WIDTH = 16;

  typedef logic [1:0] sel_t;

endpackage

// File: rtl/dmux_slot.sv
// One-entry output slot: valid flag, data register and, with DMUX_COUNT_EN,
// a wrapping count of words drained by the consumer.
module dmux_slot
  import dmux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef DMUX_COUNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
`ifdef DMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             drain;

  assign drain = valid_q && rd_ready;

  // A write wins over a drain so a full slot refills with no bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d = 1'b1;
      data_d  = wr_data;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

`ifdef DMUX_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drain) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: rtl/dmux4way_16bit_stream.sv
// Routes a valid/ready input stream to one of four one-entry output slots.
// Define DMUX_COUNT_EN to add the cnt0..cnt3 delivery counters.
module dmux4way_16bit_stream
  import dmux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  sel_t             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready
`ifdef DMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);

  logic [NUM_CH-1:0] slot_valid;
  logic [NUM_CH-1:0] slot_ready;
  logic [NUM_CH-1:0] wr_en;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
`ifdef DMUX_COUNT_EN
  logic [CNT_W-1:0]  slot_cnt  [NUM_CH];
`endif

  assign slot_ready = {out3_ready, out2_ready, out1_ready, out0_ready};

  // Selected slot can take a word if empty or draining this cycle.
  assign in_ready = !slot_valid[in_sel] || slot_ready[in_sel];

  always_comb begin
    wr_en = '0;
    if (in_valid && in_ready) wr_en[in_sel] = 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    dmux_slot #(
      .WIDTH (WIDTH)
`ifdef DMUX_COUNT_EN
      ,
      .CNT_W (CNT_W)
`endif
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[i]),
      .wr_data  (in_data),
      .rd_ready (slot_ready[i]),
      .valid    (slot_valid[i]),
      .data     (slot_data[i])
`ifdef DMUX_COUNT_EN
      ,
      .cnt      (slot_cnt[i])
`endif
    );
  end

  assign out0_valid = slot_valid[0];
  assign out1_valid = slot_valid[1];
  assign out2_valid = slot_valid[2];
  assign out3_valid = slot_valid[3];
  assign out0_data  = slot_data[0];
  assign out1_data  = slot_data[1];
  assign out2_data  = slot_data[2];
  assign out3_data  = slot_data[3];

`ifdef DMUX_COUNT_EN
  assign cnt0 = slot_cnt[0];
  assign cnt1 = slot_cnt[1];
  assign cnt2 = slot_cnt[2];
  assign cnt3 = slot_cnt[3];
`endif

endmodule

// File: tb/tb_dmux4way_16bit_stream.sv
// Bench for dmux4way_16bit_stream: slot-level model checked every cycle
// plus literal directed expectations.
module tb_dmux4way_16bit_stream;

  localparam int W  = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  od [4];
  logic [3:0]    ov;
  logic [3:0]    rdy;
`ifdef DMUX_COUNT_EN
  logic [CW-1:0] oc [4];
`endif

  dmux4way_16bit_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (od[0]),
    .out1_data  (od[1]),
    .out2_data  (od[2]),
    .out3_data  (od[3]),
    .out0_valid (ov[0]),
    .out1_valid (ov[1]),
    .out2_valid (ov[2]),
    .out3_valid (ov[3]),
    .out0_ready (rdy[0]),
    .out1_ready (rdy[1]),
    .out2_ready (rdy[2]),
    .out3_ready (rdy[3])
`ifdef DMUX_COUNT_EN
    ,
    .cnt0       (oc[0]),
    .cnt1       (oc[1]),
    .cnt2       (oc[2]),
    .cnt3       (oc[3])
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: each channel is a one-word buffer plus a delivered-word tally.
  bit          m_full [4];
  logic [W-1:0] m_word [4];
  int          m_drained [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        m_full[c] = 0;
        m_word[c] = '0;
        m_drained[c] = 0;
      end
    end else begin
      bit take;
      take = in_valid && (!m_full[in_sel] || rdy[in_sel]);
      for (int c = 0; c < 4; c++) begin
        bit gone;
        gone = m_full[c] && rdy[c];
        if (gone) m_drained[c] = m_drained[c] + 1;
        if (take && in_sel == c[1:0]) begin
          m_full[c] = 1;
          m_word[c] = in_data;
        end else if (gone) begin
          m_full[c] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_full[in_sel] || rdy[in_sel]);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("out%0d_valid", c), ov[c], m_full[c]);
      chk($sformatf("out%0d_data", c), od[c], m_word[c]);
`ifdef DMUX_COUNT_EN
      chk($sformatf("cnt%0d", c), oc[c], m_drained[c] % (1 << CW));
`endif
    end
  end

  task automatic step(input logic v, input logic [1:0] s,
                      input logic [W-1:0] d, input logic [3:0] r);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    rdy      = r;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sweep [4];

  initial begin
    sweep[0] = 16'hFFFF;
    sweep[1] = 16'h0000;
    sweep[2] = 16'hFE00;
    sweep[3] = 16'h01FF;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_sel = 2'd0;
    in_data = 16'hAAAA;
    rdy = 4'h0;
    #1;
    chk("rst in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    chk("rst out0_valid", ov[0], 0);
    chk("rst out0_data", od[0], 0);
    step(0, 0, 0, 4'h0);
    rst_n = 1'b1;
    step(0, 3, 16'h5A5A, 4'h0);
    chk("idle no capture", ov, 4'h0);

    step(1, 0, 16'hFFFF, 4'h0);
    chk("route v0", ov[0], 1);
    chk("route d0", od[0], 16'hFFFF);
    chk("route others", ov[3:1], 3'b000);

    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sel = i[1:0]; in_data = sweep[i]; rdy = 4'hF;
      #1;
      chk("sweep in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      chk("sweep data", od[i], sweep[i]);
      chk("sweep valid", ov[i], 1);
    end
    step(0, 0, 0, 4'hF);
    chk("drained all", ov, 4'h0);

    step(1, 2, 16'hA1A1, 4'hB);
    in_valid = 1; in_sel = 2; in_data = 16'hB2B2; rdy = 4'hB;
    #1;
    chk("bp in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("bp hold", od[2], 16'hA1A1);
    step(1, 2, 16'hB2B2, 4'hB);
    chk("bp hold2", od[2], 16'hA1A1);
    in_valid = 1; in_sel = 2; in_data = 16'hB2B2; rdy = 4'hF;
    #1;
    chk("bp release rdy", in_ready, 1);
    @(posedge clk);
    #1;
    chk("bp second", od[2], 16'hB2B2);
    chk("bp second v", ov[2], 1);
    step(0, 2, 0, 4'hF);

    step(1, 1, 16'h5555, 4'h0);
    step(1, 1, 16'h1234, 4'h2);
    chk("simul v1", ov[1], 1);
    chk("simul d1", od[1], 16'h1234);
    step(0, 1, 16'hDEAD, 4'h0);
    chk("ignored sel", od[1], 16'h1234);
    step(0, 1, 0, 4'hF);

    step(1, 0, 16'hC0C0, 4'h0);
    step(1, 3, 16'h3C3C, 4'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid rst v0", ov[0], 0);
    chk("mid rst v3", ov[3], 0);
    chk("mid rst d0", od[0], 0);
    chk("mid rst d3", od[3], 0);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 4'h0);
    chk("post rst", ov, 4'h0);

    for (int i = 0; i < 12; i++) begin
      logic [3:0] r;
      r = 4'(i * 5 + 3);
      step(i % 3 != 2, 2'(i * 7), 16'(i * 16'h1357), r);
    end
    step(0, 0, 0, 4'hF);

`ifdef DMUX_COUNT_EN
    rst_n = 1'b0;
    #1;
    chk("cnt rst", oc[0], 0);
    rst_n = 1'b1;
    for (int i = 0; i < 257; i++) step(1, 0, 16'(i), 4'hF);
    step(0, 0, 0, 4'hF);
    chk("cnt0 wrap", oc[0], 1);
    chk("cnt1", oc[1], 0);
    chk("cnt3", oc[3], 0);
`endif

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmux4way_16bit_stream.md
DMUX4WAY_16BIT_STREAM -- requirements
Module: dmux4way_16bit_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data path width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each per-channel delivery counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: the word to route.
REQ-006 The block SHALL have port in_sel, input, 2 bits: the destination channel, 0..3.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data and in_sel are valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-009 The block SHALL have ports out0_data..out3_data, output, WIDTH bits each: the channel data.
REQ-010 The block SHALL have ports out0_valid..out3_valid, output, 1 bit each: the channel holds a word.
REQ-011 The block SHALL have ports out0_ready..out3_ready, input, 1 bit each: the consumer takes the word.
REQ-012 When DMUX_COUNT_EN is defined, the block SHALL have ports cnt0..cnt3, output, CNT_W bits each: words delivered per channel.

Function
REQ-013 A transfer SHALL occur on a clock edge with in_valid && in_ready; a channel drain SHALL occur with outN_valid && outN_ready.
REQ-014 Each channel SHALL hold a one-entry slot with states EMPTY (outN_valid=0) and FULL (outN_valid=1).
REQ-015 in_ready SHALL be combinational: in_ready = !outS_valid || outS_ready, where S = in_sel, and it SHALL be independent of in_valid.
REQ-016 An accepted word SHALL appear on outS_data with outS_valid=1 on the cycle after the transfer, giving a latency of 1 cycle.
REQ-017 Slot transitions: EMPTY->FULL on a transfer to the channel; FULL->EMPTY on a drain without a transfer; FULL->FULL with new data on a simultaneous drain and transfer, with no bubble.
REQ-018 Channels other than in_sel SHALL be unaffected by a transfer and SHALL drain independently in the same cycle.
REQ-019 outN_data SHALL hold its last value while the channel is EMPTY, and SHALL change only on a transfer to that channel.
REQ-020 outN_valid SHALL NOT depend combinationally on outN_ready, and outN_data SHALL stay stable while the channel is FULL and not drained.
REQ-021 in_sel SHALL be ignored when in_valid=0, and no slot SHALL change state in that case.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately force outN_valid=0, outN_data=0 and cnt0..cnt3=0, regardless of the clock.
REQ-023 A word pending in a slot when reset asserts mid-operation SHALL be discarded.
REQ-024 During reset, in_ready SHALL evaluate to 1, since all slots are EMPTY, but no transfer SHALL be captured until the first edge after rst_n=1.

Configuration
REQ-025 With macro DMUX_COUNT_EN defined, each cntN SHALL increment by 1 on every drain of channel N and SHALL wrap from 2^CNT_W-1 to 0.
REQ-026 Without DMUX_COUNT_EN, the cnt ports and their counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package dmux_pkg SHALL hold the constant NUM_CH=4, the typedef sel_t (2-bit channel index), and the default WIDTH of 16.
REQ-028 The one-entry slot, with its valid flag, data register and optional counter, SHALL be the sub-module dmux_slot, instantiated four times.

Verification
REQ-029 Reset then route: in_data=16'hFFFF, sel=0 -> next cycle out0_valid=1, out0_data=16'hFFFF; other channels stay valid=0.
REQ-030 Sweep: words 16'hFFFF, 16'h0000, 16'hFE00, 16'h01FF to sel=0,1,2,3 on consecutive cycles with all outN_ready=1 -> each word appears on its own channel one cycle later, and in_ready stays 1.
REQ-031 Backpressure: out2_ready=0 and two words to sel=2 -> the first is held, in_ready=0 for the second until out2_ready=1, after which the second appears and the first is not lost.
REQ-032 Simultaneous events: channel 1 FULL, out1_ready=1 and a new word 16'h1234 to sel=1 in the same cycle -> out1_valid stays 1 and out1_data becomes 16'h1234.
REQ-033 Reset mid-operation: channels 0 and 3 FULL, rst_n pulsed low between edges -> out0_valid=out3_valid=0 and data=0 immediately.
REQ-034 With DMUX_COUNT_EN and CNT_W=8: 257 drains on channel 0 -> cnt0=1, cnt1..cnt3=0.
